// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI master round-robin scheduler.
//   wr_st_t      : write-grant FSM states
//   rd_st_t      : read-address-grant FSM states
//   rr_next_ptr  : (ptr + step) modulo 2**width, the round-robin scan order
package axi_arb_pkg;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_ADDR = 2'd1,
        WR_DATA = 2'd2
    } wr_st_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_ADDR = 1'b1
    } rd_st_t;

    function automatic int unsigned rr_next_ptr(input int unsigned ptr,
                                                input int unsigned step,
                                                input int unsigned width);
        return (ptr + step) & ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/axi_rr_pick.sv
// Combinational round-robin picker.
// Scans ptr+1, ptr+2, ... (wrapping) and returns the first requesting index.
// Ports:
//   i_req   in   2**M_WIDTH  request vector (already qualified by eligibility)
//   i_ptr   in   M_WIDTH     last winner
//   o_pick  out  M_WIDTH     selected index (0 when nothing requests)
//   o_any   out  1           at least one request present
module axi_rr_pick
    import axi_arb_pkg::*;
#(
    parameter int M_WIDTH = 2
) (
    input  logic [(1<<M_WIDTH)-1:0] i_req,
    input  logic [M_WIDTH-1:0]      i_ptr,
    output logic [M_WIDTH-1:0]      o_pick,
    output logic                    o_any
);

    localparam int unsigned N = 1 << M_WIDTH;

    logic [M_WIDTH-1:0] w_idx;

    always_comb begin
        o_any  = 1'b0;
        o_pick = '0;
        w_idx  = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            w_idx = M_WIDTH'(rr_next_ptr(32'(i_ptr), i, M_WIDTH));
            if (!o_any && i_req[w_idx]) begin
                o_any  = 1'b1;
                o_pick = w_idx;
            end
        end
    end

endmodule

// File: rtl/axi_master_rr_scheduler.sv
// Round-robin scheduler sharing one AXI bus between 2**M_WIDTH masters.
// Write grant spans AW handshake through W-last handshake; read grant spans
// until the AR handshake. B/R return selects are decoded from the ID.
// Optional macro AXI_ARB_OUTSTANDING_LIMIT_EN adds per-master outstanding
// counters that mask masters at MAX_OUTST and flag underflow in outst_err.
// Ports:
//   clk, rstn                        clock, async active-low reset
//   MASTER_WR/RD_ADDR_VALID          per-master AWVALID / ARVALID
//   BUS_* handshakes, BUS_*_BACK_ID  bus-side channel signals and BID/RID
//   wr_addr_gnt, rd_addr_gnt         grant active
//   wr_addr/wr_data/rd_addr_master_sel  registered selects
//   wr_resp/rd_data_master_sel       ID[M_ID+:M_WIDTH], combinational
//   outst_err                        sticky counter underflow
// State | meaning
//   WR_IDLE | no write grant; pick next eligible master
//   WR_ADDR | write granted, waiting for AW handshake
//   WR_DATA | AW done, waiting for W-last handshake
//   RD_IDLE | no read grant; pick next eligible master
//   RD_ADDR | read granted, waiting for AR handshake
module axi_master_rr_scheduler
    import axi_arb_pkg::*;
#(
    parameter int M_ID      = 2,
    parameter int M_WIDTH   = 2,
    parameter int MAX_OUTST = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [(1<<M_WIDTH)-1:0] MASTER_WR_ADDR_VALID,
    input  logic [(1<<M_WIDTH)-1:0] MASTER_RD_ADDR_VALID,
    input  logic                    BUS_WR_ADDR_VALID,
    input  logic                    BUS_WR_ADDR_READY,
    input  logic                    BUS_WR_DATA_VALID,
    input  logic                    BUS_WR_DATA_READY,
    input  logic                    BUS_WR_DATA_LAST,
    input  logic                    BUS_WR_BACK_VALID,
    input  logic                    BUS_WR_BACK_READY,
    input  logic [M_ID+M_WIDTH-1:0] BUS_WR_BACK_ID,
    input  logic                    BUS_RD_ADDR_VALID,
    input  logic                    BUS_RD_ADDR_READY,
    input  logic                    BUS_RD_DATA_VALID,
    input  logic                    BUS_RD_DATA_READY,
    input  logic                    BUS_RD_DATA_LAST,
    input  logic [M_ID+M_WIDTH-1:0] BUS_RD_BACK_ID,
    output logic                    wr_addr_gnt,
    output logic                    rd_addr_gnt,
    output logic [M_WIDTH-1:0]      wr_addr_master_sel,
    output logic [M_WIDTH-1:0]      wr_data_master_sel,
    output logic [M_WIDTH-1:0]      rd_addr_master_sel,
    output logic [M_WIDTH-1:0]      wr_resp_master_sel,
    output logic [M_WIDTH-1:0]      rd_data_master_sel,
    output logic                    outst_err
);

    localparam int N = 1 << M_WIDTH;

    wr_st_t             r_wr_st, w_wr_st_nxt;
    rd_st_t             r_rd_st, w_rd_st_nxt;
    logic [M_WIDTH-1:0] r_wr_sel, w_wr_sel_nxt, r_wr_ptr, w_wr_ptr_nxt;
    logic [M_WIDTH-1:0] r_rd_sel, w_rd_sel_nxt, r_rd_ptr, w_rd_ptr_nxt;
    logic               r_wr_gnt, w_wr_gnt_nxt, r_rd_gnt, w_rd_gnt_nxt;
    logic [N-1:0]       w_wr_elig, w_rd_elig;
    logic [M_WIDTH-1:0] w_wr_pick, w_rd_pick;
    logic               w_wr_any, w_rd_any;
    logic               w_aw_hs, w_wl_hs, w_ar_hs;
    logic               w_unused;

    assign w_aw_hs = BUS_WR_ADDR_VALID & BUS_WR_ADDR_READY;
    assign w_wl_hs = BUS_WR_DATA_VALID & BUS_WR_DATA_READY & BUS_WR_DATA_LAST;
    assign w_ar_hs = BUS_RD_ADDR_VALID & BUS_RD_ADDR_READY;

`ifdef AXI_ARB_OUTSTANDING_LIMIT_EN
    localparam int CW = $clog2(MAX_OUTST + 1);

    logic [CW-1:0] r_wr_cnt [N];
    logic [CW-1:0] r_rd_cnt [N];
    logic          r_outst_err;
    logic [N-1:0]  w_wr_inc, w_wr_dec, w_rd_inc, w_rd_dec;
    logic          w_b_hs, w_rl_hs;

    assign w_b_hs  = BUS_WR_BACK_VALID & BUS_WR_BACK_READY;
    assign w_rl_hs = BUS_RD_DATA_VALID & BUS_RD_DATA_READY & BUS_RD_DATA_LAST;

    always_comb begin
        w_wr_elig = '0;
        w_rd_elig = '0;
        w_wr_inc  = '0;
        w_wr_dec  = '0;
        w_rd_inc  = '0;
        w_rd_dec  = '0;
        for (int i = 0; i < N; i++) begin
            w_wr_elig[i] = MASTER_WR_ADDR_VALID[i] & (r_wr_cnt[i] < CW'(MAX_OUTST));
            w_rd_elig[i] = MASTER_RD_ADDR_VALID[i] & (r_rd_cnt[i] < CW'(MAX_OUTST));
            w_wr_inc[i]  = (r_wr_st == WR_ADDR) & w_aw_hs & (r_wr_sel == M_WIDTH'(i));
            w_rd_inc[i]  = (r_rd_st == RD_ADDR) & w_ar_hs & (r_rd_sel == M_WIDTH'(i));
            w_wr_dec[i]  = w_b_hs  & (BUS_WR_BACK_ID[M_ID+:M_WIDTH] == M_WIDTH'(i));
            w_rd_dec[i]  = w_rl_hs & (BUS_RD_BACK_ID[M_ID+:M_WIDTH] == M_WIDTH'(i));
        end
    end

    // Simultaneous inc/dec of one master cancels; a lone dec at zero saturates.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_outst_err <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_wr_cnt[i] <= '0;
                r_rd_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_wr_inc[i] && !w_wr_dec[i]) begin
                    r_wr_cnt[i] <= r_wr_cnt[i] + 1'b1;
                end else if (w_wr_dec[i] && !w_wr_inc[i]) begin
                    if (r_wr_cnt[i] == '0) r_outst_err <= 1'b1;
                    else                   r_wr_cnt[i] <= r_wr_cnt[i] - 1'b1;
                end
                if (w_rd_inc[i] && !w_rd_dec[i]) begin
                    r_rd_cnt[i] <= r_rd_cnt[i] + 1'b1;
                end else if (w_rd_dec[i] && !w_rd_inc[i]) begin
                    if (r_rd_cnt[i] == '0) r_outst_err <= 1'b1;
                    else                   r_rd_cnt[i] <= r_rd_cnt[i] - 1'b1;
                end
            end
        end
    end

    assign outst_err = r_outst_err;
    assign w_unused  = ^{BUS_WR_BACK_ID[M_ID-1:0], BUS_RD_BACK_ID[M_ID-1:0]};
`else
    logic [31:0] w_unused_max;

    assign w_wr_elig    = MASTER_WR_ADDR_VALID;
    assign w_rd_elig    = MASTER_RD_ADDR_VALID;
    assign outst_err    = 1'b0;
    assign w_unused_max = 32'(MAX_OUTST);
    assign w_unused     = ^{BUS_WR_BACK_ID[M_ID-1:0], BUS_RD_BACK_ID[M_ID-1:0],
                            BUS_WR_BACK_VALID, BUS_WR_BACK_READY, BUS_RD_DATA_VALID,
                            BUS_RD_DATA_READY, BUS_RD_DATA_LAST, w_unused_max};
`endif

    axi_rr_pick #(.M_WIDTH(M_WIDTH)) u_wr_pick (
        .i_req  (w_wr_elig),
        .i_ptr  (r_wr_ptr),
        .o_pick (w_wr_pick),
        .o_any  (w_wr_any)
    );

    axi_rr_pick #(.M_WIDTH(M_WIDTH)) u_rd_pick (
        .i_req  (w_rd_elig),
        .i_ptr  (r_rd_ptr),
        .o_pick (w_rd_pick),
        .o_any  (w_rd_any)
    );

    // Write FSM. Sels keep their value after the grant drops.
    always_comb begin
        w_wr_st_nxt  = r_wr_st;
        w_wr_sel_nxt = r_wr_sel;
        w_wr_ptr_nxt = r_wr_ptr;
        w_wr_gnt_nxt = r_wr_gnt;
        case (r_wr_st)
            WR_IDLE: if (w_wr_any) begin
                w_wr_st_nxt  = WR_ADDR;
                w_wr_sel_nxt = w_wr_pick;
                w_wr_ptr_nxt = w_wr_pick;
                w_wr_gnt_nxt = 1'b1;
            end
            WR_ADDR: if (w_aw_hs) begin
                if (w_wl_hs) begin
                    w_wr_st_nxt  = WR_IDLE;
                    w_wr_gnt_nxt = 1'b0;
                end else begin
                    w_wr_st_nxt  = WR_DATA;
                end
            end
            WR_DATA: if (w_wl_hs) begin
                w_wr_st_nxt  = WR_IDLE;
                w_wr_gnt_nxt = 1'b0;
            end
            default: begin
                w_wr_st_nxt  = WR_IDLE;
                w_wr_gnt_nxt = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_rd_st_nxt  = r_rd_st;
        w_rd_sel_nxt = r_rd_sel;
        w_rd_ptr_nxt = r_rd_ptr;
        w_rd_gnt_nxt = r_rd_gnt;
        case (r_rd_st)
            RD_IDLE: if (w_rd_any) begin
                w_rd_st_nxt  = RD_ADDR;
                w_rd_sel_nxt = w_rd_pick;
                w_rd_ptr_nxt = w_rd_pick;
                w_rd_gnt_nxt = 1'b1;
            end
            RD_ADDR: if (w_ar_hs) begin
                w_rd_st_nxt  = RD_IDLE;
                w_rd_gnt_nxt = 1'b0;
            end
            default: begin
                w_rd_st_nxt  = RD_IDLE;
                w_rd_gnt_nxt = 1'b0;
            end
        endcase
    end

    // Pointers reset to the last master so master 0 wins the first scan.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_st  <= WR_IDLE;
            r_wr_sel <= '0;
            r_wr_ptr <= '1;
            r_wr_gnt <= 1'b0;
            r_rd_st  <= RD_IDLE;
            r_rd_sel <= '0;
            r_rd_ptr <= '1;
            r_rd_gnt <= 1'b0;
        end else begin
            r_wr_st  <= w_wr_st_nxt;
            r_wr_sel <= w_wr_sel_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_wr_gnt <= w_wr_gnt_nxt;
            r_rd_st  <= w_rd_st_nxt;
            r_rd_sel <= w_rd_sel_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_rd_gnt <= w_rd_gnt_nxt;
        end
    end

    assign wr_addr_gnt        = r_wr_gnt;
    assign rd_addr_gnt        = r_rd_gnt;
    assign wr_addr_master_sel = r_wr_sel;
    assign wr_data_master_sel = r_wr_sel;
    assign rd_addr_master_sel = r_rd_sel;
    assign wr_resp_master_sel = BUS_WR_BACK_ID[M_ID+:M_WIDTH];
    assign rd_data_master_sel = BUS_RD_BACK_ID[M_ID+:M_WIDTH];

endmodule
